// File: rtl/emmc_blk_arb_if.sv
// Client-side and eMMC-SM-side signal bundle for emmc_blk_arb.
// slave = the arbiter, master = the clients plus eMMC state machine around it.
interface emmc_blk_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   we_i;
    logic [8*NREQ-1:0] wdat_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   wrd_o;
    logic [7:0]        rdat_o;
    logic [NREQ-1:0]   rvalid_o;
    logic [NREQ-1:0]   done_o;
    logic [NREQ-1:0]   err_o;
    logic              sm_we_o;
    logic              sm_start_o;
    logic [7:0]        sm_dat_o;
    logic [7:0]        sm_dat_i;
    logic              sm_dvalid_i;
    logic              sm_ready_i;

    modport slave (
        input  req_i, we_i, wdat_i, sm_dat_i, sm_dvalid_i, sm_ready_i,
        output gnt_o, wrd_o, rdat_o, rvalid_o, done_o, err_o,
               sm_we_o, sm_start_o, sm_dat_o
    );

    modport master (
        output req_i, we_i, wdat_i, sm_dat_i, sm_dvalid_i, sm_ready_i,
        input  gnt_o, wrd_o, rdat_o, rvalid_o, done_o, err_o,
               sm_we_o, sm_start_o, sm_dat_o
    );
endinterface

// File: rtl/emmc_blk_arb.sv
// Round-robin single-block arbiter/sequencer for one eMMC SM; start 2 cycles after req+ready, done 1 cycle after ready returns.
// No backpressure: the eMMC SM paces bytes via sm_dvalid_i, write clients must hold their byte until wrd_o.
module emmc_blk_arb #(
    parameter int NREQ      = 2,
    parameter int BLK_BYTES = 512,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk_i,
    input  logic              rst_i,
    emmc_blk_arb_if.slave     bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BLK_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        XFER,
        FIN
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic            sm_we_q, sm_we_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   wdog_q, wdog_d;
    logic            err_q, err_d;
    logic [7:0]      rdat_q, rdat_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            win_vld;
    logic            active;
    logic            stb;
    logic            err_fin;
    logic [7:0]      wsel;

    // Scan upward from last+1, wrapping, so the previous winner is considered last.
    always_comb begin
        win     = last_q;
        win_vld = 1'b0;
        idx     = last_q;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!win_vld && bus.req_i[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign active  = (state_q == WAIT_BUSY) || (state_q == XFER);
    assign stb     = bus.sm_dvalid_i && active;
    assign err_fin = err_q || (cnt_q != CW'(BLK_BYTES));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        sm_we_d = sm_we_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        err_d   = err_q;

        if (stb) begin
            if (cnt_q == CW'(BLK_BYTES)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.sm_ready_i && win_vld) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << win;
                    last_d  = win;
                end
            end
            GRANT: begin
                sm_we_d = |(bus.we_i & gnt_q);
                cnt_d   = '0;
                wdog_d  = '0;
                err_d   = 1'b0;
                state_d = START;
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.sm_ready_i) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (bus.sm_ready_i) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Watchdog overrides any normal transition once the budget is spent.
        if ((state_q == START) || active) begin
            wdog_d = wdog_q + 1'b1;
            if (wdog_q == TW'(TIMEOUT - 1)) begin
                state_d = FIN;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        rdat_d   = rdat_q;
        rvalid_d = '0;
        if (stb && !sm_we_q) begin
            rdat_d   = bus.sm_dat_i;
            rvalid_d = gnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            last_q   <= IW'(NREQ - 1);
            sm_we_q  <= 1'b0;
            cnt_q    <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            sm_we_q  <= sm_we_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            rvalid_q <= rvalid_d;
        end
    end

    // One-hot grant makes an OR-mux sufficient and yields zero when nothing is granted.
    always_comb begin
        wsel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                wsel = wsel | bus.wdat_i[8*k +: 8];
            end
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.sm_we_o    = sm_we_q;
    assign bus.sm_start_o = (state_q == START);
    assign bus.sm_dat_o   = wsel;
    assign bus.wrd_o      = (stb && sm_we_q) ? gnt_q : '0;
    assign bus.rdat_o     = rdat_q;
    assign bus.rvalid_o   = rvalid_q;
    assign bus.done_o     = (state_q == FIN) ? gnt_q : '0;
    assign bus.err_o      = ((state_q == FIN) && err_fin) ? gnt_q : '0;
endmodule

// File: tb/tb_emmc_blk_arb.sv
// Directed bench for emmc_blk_arb: a cycle-level eMMC SM and client model driven at negedge, sampled 1 time unit later.
module tb_emmc_blk_arb;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    emmc_blk_arb_if #(.NREQ(NREQ)) bus();

    emmc_blk_arb #(
        .NREQ      (NREQ),
        .BLK_BYTES (512),
        .TIMEOUT   (1000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0] o_gnt, o_done, o_err;
    logic            o_we;
    int              o_lat, o_xstart, o_rv, o_rvbad, o_wr, o_wrbad, o_cap, o_ohbad, o_dur;
    bit              o_to;
    int              wptr;

    task automatic drive_wdat(input int cl);
        for (int c = 0; c < NREQ; c++) begin
            bus.wdat_i[8*c +: 8] = (c == cl) ? 8'(wptr) : 8'hA5;
        end
    endtask

    // Waits for sm_start_o, then plays the SM side: ready drops the next cycle,
    // nstb strobes one per cycle, then ready returns (or ready stays low if hang).
    task automatic sm_xfer(input int nstb, input bit hang, input int cl, input bit drop_req);
        logic [NREQ-1:0] exp_oh;
        bit seen;
        exp_oh   = NREQ'(1) << cl;
        o_gnt    = '0; o_done = '0; o_err = '0; o_we = 1'b0;
        o_lat    = -1; o_xstart = 0; o_rv = 0; o_rvbad = 0; o_wr = 0; o_wrbad = 0;
        o_cap    = 0; o_ohbad = 0; o_dur = -1; o_to = 1'b0;
        wptr     = 0;
        seen     = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            bus.sm_dvalid_i = 1'b0;
            bus.sm_ready_i  = 1'b1;
            drive_wdat(cl);
            #1;
            if (bus.sm_start_o) begin
                seen  = 1'b1;
                o_lat = n + 1;
                o_gnt = bus.gnt_o;
                o_we  = bus.sm_we_o;
                break;
            end
        end
        if (!seen) begin
            o_to = 1'b1;
            return;
        end
        if (drop_req) bus.req_i = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (hang) begin
                bus.sm_ready_i  = 1'b0;
                bus.sm_dvalid_i = 1'b0;
            end else if (k < nstb) begin
                bus.sm_ready_i  = 1'b0;
                bus.sm_dvalid_i = 1'b1;
                bus.sm_dat_i    = 8'(k);
            end else begin
                bus.sm_ready_i  = 1'b1;
                bus.sm_dvalid_i = 1'b0;
                bus.sm_dat_i    = 8'h00;
            end
            drive_wdat(cl);
            #1;
            if (bus.sm_start_o) o_xstart++;
            if ($countones(bus.gnt_o) != 1) o_ohbad++;
            if (bus.rvalid_o != '0) begin
                if (bus.rvalid_o != exp_oh || bus.rdat_o != 8'(o_rv)) o_rvbad++;
                o_rv++;
            end
            if (bus.sm_dvalid_i && bus.sm_we_o) begin
                if (bus.sm_dat_o != 8'(o_cap)) o_wrbad++;
                o_cap++;
            end
            if (bus.wrd_o != '0) begin
                if (bus.wrd_o != exp_oh) o_wrbad++;
                o_wr++;
                wptr++;
            end
            if (bus.done_o != '0) begin
                o_done = bus.done_o;
                o_err  = bus.err_o;
                o_dur  = k + 1;
                return;
            end
        end
        o_to = 1'b1;
    endtask

    task automatic do_reset;
        bus.req_i       = '0;
        bus.we_i        = '0;
        bus.wdat_i      = '0;
        bus.sm_dat_i    = 8'h00;
        bus.sm_dvalid_i = 1'b0;
        bus.sm_ready_i  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic idle_step;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        int starts;
        do_reset();
        checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt_o); end
        checks++; if (bus.done_o !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", bus.done_o); end
        checks++; if (bus.err_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", bus.err_o); end
        checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", bus.rvalid_o); end
        checks++; if (bus.wrd_o !== 2'b00) begin errors++; $display("FAIL reset_wrd got %b want 00", bus.wrd_o); end
        checks++; if (bus.sm_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", bus.sm_start_o); end
        checks++; if (bus.sm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.sm_we_o); end
        checks++; if (bus.rdat_o !== 8'h00) begin errors++; $display("FAIL reset_rdat got %h want 00", bus.rdat_o); end
        checks++; if (bus.sm_dat_o !== 8'h00) begin errors++; $display("FAIL reset_smdat got %h want 00", bus.sm_dat_o); end
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            if (bus.sm_start_o !== 1'b0 || bus.gnt_o !== 2'b00) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL idle_no_req got %0d activity cycles want 0", starts); end
    endtask

    task automatic test_read_c0;
        idle_step();
        bus.we_i  = 2'b00;
        bus.req_i = 2'b01;
        sm_xfer(512, 1'b0, 0, 1'b1);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL read_bound got timeout want none"); end
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL read_latency got %0d want 2", o_lat); end
        checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL read_gnt got %b want 01", o_gnt); end
        checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL read_we got %b want 0", o_we); end
        checks++; if (o_rv !== 512) begin errors++; $display("FAIL read_count got %0d want 512", o_rv); end
        checks++; if (o_rvbad !== 0) begin errors++; $display("FAIL read_data got %0d bad bytes want 0", o_rvbad); end
        checks++; if (o_wr !== 0) begin errors++; $display("FAIL read_wrd got %0d strobes want 0", o_wr); end
        checks++; if (o_done !== 2'b01) begin errors++; $display("FAIL read_done got %b want 01", o_done); end
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL read_err got %b want 00", o_err); end
        checks++; if (o_dur !== 514) begin errors++; $display("FAIL read_duration got %0d want 514", o_dur); end
        checks++; if (o_xstart !== 0) begin errors++; $display("FAIL read_extra_start got %0d want 0", o_xstart); end
        checks++; if (o_ohbad !== 0) begin errors++; $display("FAIL read_onehot got %0d bad cycles want 0", o_ohbad); end
    endtask

    task automatic test_write_c1;
        idle_step();
        bus.we_i  = 2'b10;
        bus.req_i = 2'b10;
        sm_xfer(512, 1'b0, 1, 1'b1);
        checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL write_bound got timeout want none"); end
        checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL write_gnt got %b want 10", o_gnt); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL write_we got %b want 1", o_we); end
        checks++; if (o_wr !== 512) begin errors++; $display("FAIL write_wrd got %0d want 512", o_wr); end
        checks++; if (o_cap !== 512) begin errors++; $display("FAIL write_captured got %0d want 512", o_cap); end
        checks++; if (o_wrbad !== 0) begin errors++; $display("FAIL write_data got %0d bad bytes want 0", o_wrbad); end
        checks++; if (o_rv !== 0) begin errors++; $display("FAIL write_rvalid got %0d want 0", o_rv); end
        checks++; if (o_done !== 2'b10) begin errors++; $display("FAIL write_done got %b want 10", o_done); end
        checks++; if (o_err !== 2'b00) begin errors++; $display("FAIL write_err got %b want 00", o_err); end
        checks++; if (o_xstart !== 0) begin errors++; $display("FAIL write_extra_start got %0d want 0", o_xstart); end
        bus.we_i = 2'b00;
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] exp_g;
        do_reset();
        bus.req_i = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            sm_xfer(512, 1'b0, r % 2, 1'b0);
            checks++; if (o_gnt !== exp_g) begin errors++; $display("FAIL contention_gnt%0d got %b want %b", r, o_gnt, exp_g); end
            checks++; if (o_done !== exp_g || o_err !== 2'b00) begin errors++; $display("FAIL contention_done%0d got %b/%b want %b/00", r, o_done, o_err, exp_g); end
            checks++; if (o_ohbad !== 0) begin errors++; $display("FAIL contention_onehot%0d got %0d want 0", r, o_ohbad); end
        end
        bus.req_i = 2'b00;
    endtask

    task automatic test_short_overflow;
        idle_step();
        bus.req_i = 2'b01;
        sm_xfer(300, 1'b0, 0, 1'b1);
        checks++; if (o_done !== 2'b01) begin errors++; $display("FAIL short_done got %b want 01", o_done); end
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL short_err got %b want 01", o_err); end
        checks++; if (o_dur !== 302) begin errors++; $display("FAIL short_duration got %0d want 302", o_dur); end
        idle_step();
        bus.req_i = 2'b01;
        sm_xfer(513, 1'b0, 0, 1'b1);
        checks++; if (o_done !== 2'b01) begin errors++; $display("FAIL overflow_done got %b want 01", o_done); end
        checks++; if (o_err !== 2'b01) begin errors++; $display("FAIL overflow_err got %b want 01", o_err); end
    endtask

    task automatic test_timeout;
        int starts;
        idle_step();
        bus.req_i = 2'b10;
        sm_xfer(0, 1'b1, 1, 1'b0);
        checks++; if (o_dur !== 1000) begin errors++; $display("FAIL timeout_cycle got %0d want 1000", o_dur); end
        checks++; if (o_done !== 2'b10 || o_err !== 2'b10) begin errors++; $display("FAIL timeout_pulse got %b/%b want 10/10", o_done, o_err); end
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.sm_ready_i  = 1'b0;
            bus.sm_dvalid_i = 1'b0;
            #1;
            if (bus.sm_start_o) starts++;
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL timeout_no_restart got %0d starts want 0", starts); end
        bus.req_i = 2'b11;
        sm_xfer(512, 1'b0, 0, 1'b1);
        checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL timeout_next_gnt got %b want 01", o_gnt); end
        checks++; if (o_done !== 2'b01 || o_err !== 2'b00) begin errors++; $display("FAIL timeout_recover got %b/%b want 01/00", o_done, o_err); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int dones;
        idle_step();
        bus.we_i  = 2'b10;
        bus.req_i = 2'b10;
        seen  = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            idle_step();
            if (bus.sm_start_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_start got none want start"); end
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            bus.sm_ready_i  = 1'b0;
            bus.sm_dvalid_i = (k < 100);
            bus.sm_dat_i    = 8'(k);
            if (k == 100) rst = 1'b1;
            #1;
            if (bus.done_o != '0) dones++;
        end
        @(negedge clk);
        rst             = 1'b0;
        bus.sm_ready_i  = 1'b1;
        bus.sm_dvalid_i = 1'b0;
        bus.req_i       = 2'b00;
        #1;
        checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", dones); end
        checks++; if (bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00 || bus.err_o !== 2'b00)
            begin errors++; $display("FAIL rstmid_ctl got gnt %b done %b err %b want 00", bus.gnt_o, bus.done_o, bus.err_o); end
        checks++; if (bus.wrd_o !== 2'b00 || bus.rvalid_o !== 2'b00 || bus.sm_start_o !== 1'b0 || bus.sm_we_o !== 1'b0)
            begin errors++; $display("FAIL rstmid_strobes got wrd %b rv %b st %b we %b want 0", bus.wrd_o, bus.rvalid_o, bus.sm_start_o, bus.sm_we_o); end
        checks++; if (bus.sm_dat_o !== 8'h00 || bus.rdat_o !== 8'h00)
            begin errors++; $display("FAIL rstmid_data got smdat %h rdat %h want 00", bus.sm_dat_o, bus.rdat_o); end
        bus.we_i  = 2'b00;
        bus.req_i = 2'b11;
        sm_xfer(512, 1'b0, 0, 1'b1);
        checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL rstmid_first_gnt got %b want 01", o_gnt); end
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL rstmid_latency got %0d want 2", o_lat); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_read_c0();
        test_write_c1();
        test_contention();
        test_short_overflow();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
